// File: rtl/fnd_pkg.sv
// Shared constants and types for the FND scan decoder: segment codes (active-low,
// {g,f,e,d,c,b,a}), digit-enable codes and the settle FSM state type.
package fnd_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] COM_D0  = 4'b1110;
  localparam logic [3:0] COM_D1  = 4'b1101;
  localparam logic [3:0] COM_D2  = 4'b1011;
  localparam logic [3:0] COM_D3  = 4'b0111;
  localparam logic [3:0] COM_OFF = 4'b1111;

  typedef enum logic {
    ST_WAIT_SETTLE,
    ST_LATCHED
  } fnd_state_e;

  // Four BCD digits {d3,d2,d1,d0} to binary; the result never exceeds 9999.
  function automatic logic [13:0] bcd4_to_bin(input logic [15:0] bcd);
    return 14'(bcd[15:12]) * 14'd1000
         + 14'(bcd[11:8])  * 14'd100
         + 14'(bcd[7:4])   * 14'd10
         + 14'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/fnd_scan_decoder_if.sv
// FND display bus plus the decoded frame readback; the display side is master,
// the decoder is slave.
interface fnd_scan_decoder_if;

  logic [3:0]  fnd_com;
  logic [6:0]  fnd_data;
  logic [15:0] digits_bcd;
  logic [13:0] value;
  logic [3:0]  blank_mask;
  logic [3:0]  err_mask;
  logic        frame_valid;
  logic        changed;
  logic        com_err;
  logic        stale;

  modport master (
    output fnd_com, fnd_data,
    input  digits_bcd, value, blank_mask, err_mask,
    input  frame_valid, changed, com_err, stale
  );

  modport slave (
    input  fnd_com, fnd_data,
    output digits_bcd, value, blank_mask, err_mask,
    output frame_valid, changed, com_err, stale
  );

endinterface

// File: rtl/fnd_seg_decode.sv
// Combinational seven-segment pattern to BCD decode; blank and unknown patterns
// both read as digit 0 and are told apart by their flags.
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       blank_o,
  output logic       err_o
);

  always_comb begin
    bcd_o   = 4'd0;
    blank_o = 1'b0;
    err_o   = 1'b0;
    case (seg_i)
      SEG_0:     bcd_o = 4'd0;
      SEG_1:     bcd_o = 4'd1;
      SEG_2:     bcd_o = 4'd2;
      SEG_3:     bcd_o = 4'd3;
      SEG_4:     bcd_o = 4'd4;
      SEG_5:     bcd_o = 4'd5;
      SEG_6:     bcd_o = 4'd6;
      SEG_7:     bcd_o = 4'd7;
      SEG_8:     bcd_o = 4'd8;
      SEG_9:     bcd_o = 4'd9;
      SEG_BLANK: blank_o = 1'b1;
      default:   err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Receive side of the 4-digit multiplexed FND bus: settles each scan dwell,
// decodes segments back to BCD and publishes complete frames.
//   state          | meaning
//   ST_WAIT_SETTLE | counting identical samples of {com, data}
//   ST_LATCHED     | dwell consumed; hold until the bus moves, check frame completion
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic               clk,
  input logic               rst,
  fnd_scan_decoder_if.slave bus
);

  localparam int unsigned      CNT_W       = 8;
  localparam int unsigned      TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
  // settle_q holds (identical samples - 2) while the pair is steady
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [TMO_W-1:0] TMO_MAX     = TMO_W'(TIMEOUT_CYCLES);

  logic [3:0]       com_q, com_prev_q;
  logic [6:0]       data_q, data_prev_q;
  logic [CNT_W-1:0] settle_q, settle_d;
  fnd_state_e       state_q, state_d;
  logic             same, latch, frame_done;

  logic [3:0]       slot_sel;
  logic             com_multi;
  logic [3:0]       dec_bcd;
  logic             dec_blank, dec_err;

  logic [15:0]      slot_bcd_q, slot_bcd_d;
  logic [3:0]       slot_blank_q, slot_blank_d;
  logic [3:0]       slot_err_q, slot_err_d;
  logic [3:0]       seen_q, seen_d;

  logic [15:0]      digits_q;
  logic [13:0]      value_q;
  logic [3:0]       blank_q, err_q;
  logic             frame_valid_q, changed_q, com_err_q, have_frame_q;
  logic             changed_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  fnd_seg_decode u_seg_decode (
    .seg_i   (data_q),
    .bcd_o   (dec_bcd),
    .blank_o (dec_blank),
    .err_o   (dec_err)
  );

  assign same = (com_q == com_prev_q) && (data_q == data_prev_q);

  always_comb begin
    settle_d = '0;
    if (same) begin
      settle_d = (settle_q == CNT_MAX) ? settle_q : settle_q + 1'b1;
    end
  end

  always_comb begin
    slot_sel  = 4'b0000;
    com_multi = 1'b0;
    case (com_q)
      COM_D0:  slot_sel = 4'b0001;
      COM_D1:  slot_sel = 4'b0010;
      COM_D2:  slot_sel = 4'b0100;
      COM_D3:  slot_sel = 4'b1000;
      COM_OFF: slot_sel = 4'b0000;
      default: com_multi = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    latch      = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_WAIT_SETTLE: begin
        if (same && (settle_q == SETTLE_LAST)) begin
          latch   = 1'b1;
          state_d = ST_LATCHED;
        end
      end
      ST_LATCHED: begin
        frame_done = (seen_q == 4'b1111);
        if (!same) begin
          state_d = ST_WAIT_SETTLE;
        end
      end
      default: state_d = ST_WAIT_SETTLE;
    endcase
  end

  always_comb begin
    slot_bcd_d   = slot_bcd_q;
    slot_blank_d = slot_blank_q;
    slot_err_d   = slot_err_q;
    seen_d       = seen_q;
    if (latch) begin
      for (int i = 0; i < 4; i++) begin
        if (slot_sel[i]) begin
          slot_bcd_d[4*i +: 4] = dec_bcd;
          slot_blank_d[i]      = dec_blank;
          slot_err_d[i]        = dec_err;
          seen_d[i]            = 1'b1;
        end
      end
    end
    if (frame_done) begin
      seen_d = 4'b0000;
    end
  end

  // First frame after reset always reports a change, even an all-zero one.
  assign changed_d = frame_done &&
                     (!have_frame_q || (slot_bcd_q != digits_q) || (slot_blank_q != blank_q));

  // A completing frame beats saturation so stale cannot flash on that edge.
  always_comb begin
    tmo_d = tmo_q;
    if (frame_done) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      com_q         <= COM_OFF;
      data_q        <= SEG_BLANK;
      com_prev_q    <= COM_OFF;
      data_prev_q   <= SEG_BLANK;
      settle_q      <= '0;
      state_q       <= ST_WAIT_SETTLE;
      slot_bcd_q    <= '0;
      slot_blank_q  <= '0;
      slot_err_q    <= '0;
      seen_q        <= '0;
      digits_q      <= '0;
      value_q       <= '0;
      blank_q       <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
      changed_q     <= 1'b0;
      com_err_q     <= 1'b0;
      have_frame_q  <= 1'b0;
      tmo_q         <= '0;
    end else begin
      com_q         <= bus.fnd_com;
      data_q        <= bus.fnd_data;
      com_prev_q    <= com_q;
      data_prev_q   <= data_q;
      settle_q      <= settle_d;
      state_q       <= state_d;
      slot_bcd_q    <= slot_bcd_d;
      slot_blank_q  <= slot_blank_d;
      slot_err_q    <= slot_err_d;
      seen_q        <= seen_d;
      frame_valid_q <= frame_done;
      changed_q     <= changed_d;
      com_err_q     <= latch && com_multi;
      tmo_q         <= tmo_d;
      if (frame_done) begin
        digits_q     <= slot_bcd_q;
        value_q      <= bcd4_to_bin(slot_bcd_q);
        blank_q      <= slot_blank_q;
        err_q        <= slot_err_q;
        have_frame_q <= 1'b1;
      end
    end
  end

  assign bus.digits_bcd  = digits_q;
  assign bus.value       = value_q;
  assign bus.blank_mask  = blank_q;
  assign bus.err_mask    = err_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.changed     = changed_q;
  assign bus.com_err     = com_err_q;
  assign bus.stale       = (tmo_q == TMO_MAX);

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Scoreboard bench for fnd_scan_decoder: scans frames onto the FND bus, predicts
// each frame from segment-table rules and checks it when frame_valid appears.
module tb_fnd_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 1000;

  typedef struct {
    logic [15:0] digits;
    logic [13:0] value;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic        changed;
  } exp_t;

  logic clk;
  logic rst;
  fnd_scan_decoder_if bus ();

  fnd_scan_decoder #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [6:0] BLK = 7'h7F;

  exp_t        sb_q [$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          com_err_cnt = 0;
  bit          first_frame = 1'b1;
  logic [15:0] prev_digits = '0;
  logic [3:0]  prev_blank = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic classify(input logic [6:0] p, output logic [3:0] d, output logic b, output logic e);
    d = 4'd0;
    b = (p == BLK);
    e = !b;
    for (int i = 0; i < 10; i++) begin
      if (p == seg_tbl[i]) begin
        d = 4'(i);
        e = 1'b0;
      end
    end
  endtask

  // pats = {thousands, hundreds, tens, ones} segment patterns
  task automatic model_push(input logic [27:0] pats);
    exp_t       x;
    logic [3:0] d;
    logic       b, er;
    int         v;
    x.digits = '0;
    x.blank  = '0;
    x.err    = '0;
    for (int s = 0; s < 4; s++) begin
      classify(pats[7*s +: 7], d, b, er);
      x.digits[4*s +: 4] = d;
      x.blank[s]         = b;
      x.err[s]           = er;
    end
    v = 0;
    for (int s = 3; s >= 0; s--) v = v * 10 + int'(x.digits[4*s +: 4]);
    x.value   = 14'(v);
    x.changed = first_frame || (x.digits != prev_digits) || (x.blank != prev_blank);
    prev_digits = x.digits;
    prev_blank  = x.blank;
    first_frame = 1'b0;
    sb_q.push_back(x);
  endtask

  function automatic logic [3:0] com_of(input int s);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << s);
  endfunction

  task automatic hold(input logic [3:0] com, input logic [6:0] dat, input int n);
    bus.fnd_com  = com;
    bus.fnd_data = dat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [27:0] pats, input int dwell, input int glitch_slot);
    model_push(pats);
    for (int s = 0; s < 4; s++) begin
      if (s == glitch_slot) begin
        hold(com_of(s), pats[7*s +: 7], 40);
        hold(com_of(s), 7'h00, SETTLE - 1);
        hold(com_of(s), pats[7*s +: 7], dwell - 40 - (SETTLE - 1));
      end else begin
        hold(com_of(s), pats[7*s +: 7], dwell);
      end
    end
  endtask

  function automatic logic [27:0] num(input int d3, input int d2, input int d1, input int d0);
    return {seg_tbl[d3], seg_tbl[d2], seg_tbl[d1], seg_tbl[d0]};
  endfunction

  function automatic logic [6:0] rand_pat();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return seg_tbl[$urandom_range(0, 9)];
    if (r < 85) return BLK;
    return 7'($urandom);
  endfunction

  task automatic reset_dut(input string tag);
    rst          = 1'b1;
    bus.fnd_com  = 4'b1111;
    bus.fnd_data = BLK;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_digits"}, 32'(bus.digits_bcd), 0);
    check({tag, "_value"},  32'(bus.value), 0);
    check({tag, "_blank"},  32'(bus.blank_mask), 0);
    check({tag, "_err"},    32'(bus.err_mask), 0);
    check({tag, "_fvalid"}, 32'(bus.frame_valid), 0);
    check({tag, "_stale"},  32'(bus.stale), 0);
    rst         = 1'b0;
    first_frame = 1'b1;
    prev_digits = '0;
    prev_blank  = '0;
  endtask

  task automatic drain(input string tag);
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_pending_frames"}, 32'(sb_q.size()), 0);
    sb_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.com_err) com_err_cnt++;
      if (bus.changed && !bus.frame_valid) begin
        n_cmp++;
        n_mis++;
        $display("FAIL changed_alone: got changed=1 with frame_valid=0, expected changed=0");
      end
      if (bus.frame_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_frame: got frame_valid=1 (value %0d), expected no frame", bus.value);
        end else begin
          mon_e = sb_q.pop_front();
          check("frame_digits",  32'(bus.digits_bcd), 32'(mon_e.digits));
          check("frame_value",   32'(bus.value),      32'(mon_e.value));
          check("frame_blank",   32'(bus.blank_mask), 32'(mon_e.blank));
          check("frame_err",     32'(bus.err_mask),   32'(mon_e.err));
          check("frame_changed", 32'(bus.changed),    32'(mon_e.changed));
        end
      end
    end
  end

  initial begin
    int ce0;
    logic [27:0] pats;
    rst          = 1'b1;
    bus.fnd_com  = 4'b1111;
    bus.fnd_data = BLK;
    reset_dut("rst0");

    scan(num(1, 2, 3, 4), 100, -1);
    scan(num(1, 2, 3, 4), 100, -1);
    scan(num(1, 2, 3, 5), 100, -1);
    scan(num(1, 2, 3, 5), 100, 1);
    scan({BLK, BLK, seg_tbl[7], seg_tbl[5]}, 100, -1);
    scan({BLK, BLK, 7'h36, seg_tbl[5]}, 100, -1);

    // Illegal two-digit enable between tens and hundreds must not disturb the frame.
    model_push(num(1, 2, 3, 4));
    ce0 = com_err_cnt;
    hold(com_of(0), seg_tbl[4], 50);
    hold(com_of(1), seg_tbl[3], 50);
    hold(4'b1100, seg_tbl[8], 10);
    hold(com_of(2), seg_tbl[2], 50);
    hold(com_of(3), seg_tbl[1], 50);
    check("com_err_pulses", 32'(com_err_cnt - ce0), 1);

    for (int k = 0; k < 20; k++) begin
      pats = {rand_pat(), rand_pat(), rand_pat(), rand_pat()};
      scan(pats, $urandom_range(SETTLE + 2, 20), -1);
    end
    drain("scan");

    reset_dut("rst_stale");
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("stale_before_limit", 32'(bus.stale), 0);
    @(posedge clk);
    #1;
    check("stale_at_limit", 32'(bus.stale), 1);

    scan(num(9, 8, 7, 6), 100, -1);
    check("stale_cleared", 32'(bus.stale), 0);

    hold(com_of(0), seg_tbl[5], 100);
    hold(com_of(1), seg_tbl[5], 100);
    reset_dut("rst_mid");
    scan(num(0, 0, 0, 0), 100, -1);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fnd_scan_decoder.md
# fnd_scan_decoder

Receiving end of the 4-digit multiplexed seven-segment (FND) display bus driven by the calculator's display controller. Samples `fnd_com`/`fnd_data`, rejects scan-transition glitches, decodes each segment pattern back to a BCD digit, and assembles a complete 4-digit frame. Outputs the frame as BCD and binary, with per-digit blank/error flags. Used as an in-fabric checker and readback path for the display, so benches and self-test logic can compare the shown value against the computed sum.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive identical samples required before a digit is latched (legal range 2..255).
- `TIMEOUT_CYCLES`, default 1_000_000: cycles without a completed frame before `stale` asserts.

- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `fnd_com` in 4: digit enables, active-low; 4'b1110 = ones, 4'b1101 = tens, 4'b1011 = hundreds, 4'b0111 = thousands.
- `fnd_data` in 7: segments, active-low, bit order {g,f,e,d,c,b,a}.
- `digits_bcd` out 16: {thousands, hundreds, tens, ones}, 4 bits each.
- `value` out 14: binary value, range 0..9999.
- `blank_mask` out 4: digit shown blank (7'h7F); bit 0 = ones.
- `err_mask` out 4: digit pattern not 0–9 and not blank.
- `frame_valid` out 1: one-cycle pulse; all frame outputs update on this cycle.
- `changed` out 1: one-cycle pulse with `frame_valid` when `digits_bcd` or `blank_mask` differs from the previous frame.
- `com_err` out 1: one-cycle pulse when a settled `fnd_com` has more than one low bit.
- `stale` out 1: level; no frame completed within `TIMEOUT_CYCLES`.

## Operation
- Input stage registers `fnd_com` and `fnd_data` every cycle.
- The settle counter increments while the registered {com, data} equals the previous sample, and resets to 0 on any change.
- Latch event: occurs once per dwell, on the edge where the pair has been sampled identical `SETTLE_CYCLES` times. No further latch occurs until the pair changes.
- On a latch event, `fnd_com` is classified:
  - Exactly one low bit: decode `fnd_data` into that digit slot and set the slot's seen bit.
  - 4'b1111: display off; ignored.
  - Two or more low bits: pulse `com_err`; no slot is written.
- Segment decode: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Blank (7'h7F) gives digit 0 with the blank bit set.
  - Any other pattern gives digit 0 with the err bit set.
- A repeated slot before the frame completes overwrites that slot's digit and flags.
- When the seen mask reaches 4'b1111:
  - Register `digits_bcd`, `blank_mask`, `err_mask`, and `value` = d3·1000 + d2·100 + d1·10 + d0.
  - Pulse `frame_valid`, evaluate `changed`, clear the seen mask, and restart the timeout counter.
- `changed` on the first frame after reset is 1.
- Timeout counter: counts every cycle; saturates at `TIMEOUT_CYCLES`. `stale` = 1 while the counter equals `TIMEOUT_CYCLES`. It is cleared by `frame_valid`.
- FSM:
  - WAIT_SETTLE: counting.
  - LATCHED: digit taken; hold until the input changes, then return to WAIT_SETTLE.
  - Frame completion is evaluated in LATCHED.

## Timing
- Reset values: `digits_bcd`=0, `value`=0, `blank_mask`=0, `err_mask`=0, `frame_valid`=0, `changed`=0, `com_err`=0, `stale`=0, seen mask=0, counters=0, FSM=WAIT_SETTLE.
- A pair stable from edge N at the input is latched at edge N+`SETTLE_CYCLES` (one edge for the input register, then `SETTLE_CYCLES`−1 compare edges).
- `frame_valid` and `changed` go high at the edge after the 4th-slot latch and last one cycle. Frame outputs change on that same edge.
- `com_err` is high the cycle after the latch edge.
- Glitches shorter than `SETTLE_CYCLES` samples never latch.
- `rst` asserted mid-frame discards partial slots. Previous frame outputs return to reset values.
- Simultaneous frame completion and timeout saturation: `frame_valid` wins and `stale` stays 0.

## Structure
- Package `fnd_pkg`:
  - `SEG_0`..`SEG_9` and `SEG_BLANK` constants.
  - `COM_D0`..`COM_D3` codes.
  - FSM state type.
- Sub-module `fnd_seg_decode`: combinational 7-bit pattern → {bcd[3:0], blank, err}. Shared with the display encoder's self-check.
- Top level holds the input register, settle counter, FSM, slot registers, seen mask, BCD-to-binary register, and timeout counter.

## Test plan
- Scan "1234" (each digit dwells 100 cycles, ones first) → one `frame_valid` with `digits_bcd`=16'h1234, `value`=1234, masks 0, `changed`=1.
- Same scan repeated → second `frame_valid` with `changed`=0. Then scan "1235" → `changed`=1 and `value`=1235.
- Insert 3-cycle glitch `fnd_data`=7'h00 in the tens dwell (`SETTLE_CYCLES`=4) → no effect; `value` unchanged.
- Scan blank, blank, 7, 5 → `blank_mask`=4'b1100, `value`=75. Tens pattern 7'h36 → `err_mask`=4'b0010 and that digit reads 0.
- `fnd_com`=4'b1100 held 10 cycles → single `com_err` pulse; seen mask unaltered.
- Stop scanning with `TIMEOUT_CYCLES`=1000 → `stale`=1 at cycle 1000. Assert `rst` after two digits of the next scan → outputs 0 and no `frame_valid` until four fresh digits are latched.
